// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: ALU load/store codes,
// FSM states and the request decoder.
package load_store_unit_pkg;

    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        CAP,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_signed;
        logic [2:0] nbytes;
    } lsu_op_t;

    function automatic lsu_op_t decode_op(input logic [5:0] alucode);
        lsu_op_t op;
        op = '0;
        case (alucode)
            ALU_LB:  op = '{legal: 1'b1, is_load: 1'b1, is_signed: 1'b1, nbytes: 3'd1};
            ALU_LH:  op = '{legal: 1'b1, is_load: 1'b1, is_signed: 1'b1, nbytes: 3'd2};
            ALU_LW:  op = '{legal: 1'b1, is_load: 1'b1, is_signed: 1'b0, nbytes: 3'd4};
            ALU_LBU: op = '{legal: 1'b1, is_load: 1'b1, is_signed: 1'b0, nbytes: 3'd1};
            ALU_LHU: op = '{legal: 1'b1, is_load: 1'b1, is_signed: 1'b0, nbytes: 3'd2};
            ALU_SB:  op = '{legal: 1'b1, is_load: 1'b0, is_signed: 1'b0, nbytes: 3'd1};
            ALU_SH:  op = '{legal: 1'b1, is_load: 1'b0, is_signed: 1'b0, nbytes: 3'd2};
            ALU_SW:  op = '{legal: 1'b1, is_load: 1'b0, is_signed: 1'b0, nbytes: 3'd4};
            default: op = '0;
        endcase
        return op;
    endfunction

    // True when the access runs past the end of its first word.
    function automatic logic crosses_word(input logic [1:0] offset, input logic [2:0] nbytes);
        return ({1'b0, offset} + nbytes) > 3'd4;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake and word-memory port of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_alucode;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_alucode, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_alucode, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering between little-endian pipeline data and the memory word
// layout, where byte offset k lives in bits [31-8k:24-8k] with write enable bit 3-k.
module lsu_lane_align (
    input  logic [1:0]  offset,
    input  logic [2:0]  nbytes,
    input  logic        is_signed,
    input  logic [31:0] sdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [3:0]  we0,
    output logic [3:0]  we1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] ldata
);
    logic [2:0]  pos;
    logic [1:0]  lane;
    logic [31:0] raw;

    // Route each request byte to its lane in word 0 or word 1, and gather loaded bytes back.
    always_comb begin
        we0    = '0;
        we1    = '0;
        wdata0 = '0;
        wdata1 = '0;
        raw    = '0;
        pos    = '0;
        lane   = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (3'(j) < nbytes) begin
                pos  = {1'b0, offset} + 3'(j);
                // Lane bit position counted from bit 0 is 3 - (byte offset in word).
                lane = ~pos[1:0];
                if (pos[2]) begin
                    we1[lane]                   = 1'b1;
                    wdata1[{lane, 3'b000} +: 8] = sdata[8*j +: 8];
                    raw[8*j +: 8]               = word1[{lane, 3'b000} +: 8];
                end else begin
                    we0[lane]                   = 1'b1;
                    wdata0[{lane, 3'b000} +: 8] = sdata[8*j +: 8];
                    raw[8*j +: 8]               = word0[{lane, 3'b000} +: 8];
                end
            end
        end
    end

    // Sign- or zero-extend the gathered load value.
    always_comb begin
        ldata = raw;
        if (is_signed) begin
            if (nbytes == 3'd1) begin
                ldata[31:8] = {24{raw[7]}};
            end else if (nbytes == 3'd2) begin
                ldata[31:16] = {16{raw[15]}};
            end
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one MEM-stage request at a time and drives the
// word-organised data memory. Word-crossing accesses are split into two word
// accesses when LSU_MISALIGN_SPLIT_EN is defined; otherwise they are rejected
// with resp_err and no memory access.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);
    lsu_state_t         state;
    lsu_state_t         state_next;
    lsu_op_t            in_op;
    logic               in_err;
    logic               ld_q;
    logic               sign_q;
    logic [2:0]         nbytes_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        word0_q;
    logic [31:0]        resp_data_q;
    logic               resp_err_q;
    logic               cur_cross;
    logic [ADDR_W-1:0]  word_addr;
    logic [3:0]         we0;
    logic [3:0]         we1;
    logic [31:0]        wd0;
    logic [31:0]        wd1;
    logic [31:0]        ld_word0;
    logic [31:0]        ld_result;

    assign in_op = decode_op(bus.req_alucode);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign in_err = !in_op.legal;
`else
    assign in_err = !in_op.legal || crosses_word(bus.req_addr[1:0], in_op.nbytes);
`endif

    assign cur_cross = crosses_word(addr_q[1:0], nbytes_q);
    assign word_addr = addr_q[ADDR_W+1:2];
    // On a split load the first word was parked in word0_q; otherwise it arrives now.
    assign ld_word0  = cur_cross ? word0_q : bus.mem_rdata;

    lsu_lane_align u_align (
        .offset    (addr_q[1:0]),
        .nbytes    (nbytes_q),
        .is_signed (sign_q),
        .sdata     (wdata_q),
        .word0     (ld_word0),
        .word1     (bus.mem_rdata),
        .we0       (we0),
        .we1       (we1),
        .wdata0    (wd0),
        .wdata1    (wd1),
        .ldata     (ld_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing through the word accesses.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = in_err ? RESP : ACC0;
                end
            end
            ACC0: begin
                state_next = ld_q ? CAP : RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (cur_cross) begin
                    state_next = ACC1;
                end
`endif
            end
            ACC1:    state_next = ld_q ? CAP : RESP;
            CAP:     state_next = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches, first-word capture and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q        <= 1'b0;
            sign_q      <= 1'b0;
            nbytes_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word0_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ld_q        <= in_op.is_load;
                        sign_q      <= in_op.is_signed;
                        nbytes_q    <= in_op.nbytes;
                        addr_q      <= bus.req_addr[ADDR_W+1:0];
                        wdata_q     <= bus.req_wdata;
                        resp_data_q <= '0;
                        resp_err_q  <= in_err;
                    end
                end
                ACC1:    word0_q <= bus.mem_rdata;
                CAP:     resp_data_q <= ld_result;
                default: ;
            endcase
        end
    end

    // Memory port: strobes only while in an access state.
    always_comb begin
        bus.mem_addr  = word_addr;
        bus.mem_re    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_wdata = '0;
        case (state)
            ACC0: begin
                bus.mem_re    = ld_q;
                bus.mem_we    = ld_q ? 4'b0000 : we0;
                bus.mem_wdata = wd0;
            end
            ACC1: begin
                bus.mem_addr  = word_addr + ADDR_W'(1);
                bus.mem_re    = ld_q;
                bus.mem_we    = ld_q ? 4'b0000 : we1;
                bus.mem_wdata = wd1;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory
// accesses and responses; negedge monitors pop and compare.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned AW = 15;

    typedef struct {
        logic [AW-1:0] addr;
        logic          re;
        logic [3:0]    we;
        logic [31:0]   wdata;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;
    bit   seen = 1'b0;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    logic [31:0] mem [0:(1<<AW)-1];

    load_store_unit_if #(.ADDR_W(AW)) bus ();

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event did not match expectation (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    // Word memory: lane writes, read data registered one cycle after mem_re.
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.mem_we[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Memory access monitor.
    always @(negedge clk) begin
        if (mon_en && (bus.mem_re || bus.mem_we != 4'b0000)) begin
            if (acc_q.size() == 0) begin
                fail_now("mem_unexpected_access");
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                check("mem_access", {bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata & lane_mask(bus.mem_we)},
                      {e.addr, e.re, e.we, e.wdata & lane_mask(e.we)});
            end
        end
    end

    // Response monitor: latency on first sight, data/err held every valid cycle.
    always @(negedge clk) begin
        if (mon_en && bus.resp_valid) begin
            if (rsp_q.size() == 0) begin
                fail_now("resp_unexpected");
            end else begin
                if (!seen) begin
                    check("resp_latency", cyc, rsp_q[0].due);
                    seen = 1'b1;
                end
                check("resp_data", bus.resp_data, rsp_q[0].data);
                check("resp_err", bus.resp_err, rsp_q[0].err);
                check("req_ready_in_resp", bus.req_ready, 0);
                if (bus.resp_ready) begin
                    void'(rsp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic exp_acc(input logic [AW-1:0] a, input logic re, input logic [3:0] we, input logic [31:0] wd);
        acc_t e;
        e.addr = a; e.re = re; e.we = we; e.wdata = wd;
        acc_q.push_back(e);
    endtask

    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                        input bit want_rsp, input logic [31:0] ed, input logic ee, input int lat);
        int t;
        rsp_t r;
        @(posedge clk); #1;
        bus.req_valid   = 1'b1;
        bus.req_alucode = op;
        bus.req_addr    = a;
        bus.req_wdata   = d;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.req_ready) begin
            fail_now("accept_timeout");
        end else if (want_rsp) begin
            r.data = ed; r.err = ee; r.due = cyc + lat;
            rsp_q.push_back(r);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0 || !bus.req_ready) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (rsp_q.size() != 0 || acc_q.size() != 0 || !bus.req_ready) fail_now("completion_timeout");
    endtask

    initial begin
        int t;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_alucode = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_re", bus.mem_re, 0);
        check("rst_resp_data_err", {bus.resp_err, bus.resp_data}, 0);
        check("rst_mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Aligned word store then load back.
        exp_acc(4, 0, 4'b1111, 32'h44332211);
        send(ALU_SW, 32'h10, 32'h11223344, 1, 32'h0, 0, 2); wait_done();
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LW, 32'h10, 32'h0, 1, 32'h11223344, 0, 3); wait_done();

        // Byte store at offset 3, sign/zero-extended byte and halfword loads.
        exp_acc(4, 0, 4'b0001, 32'h00000080);
        send(ALU_SB, 32'h13, 32'h80, 1, 32'h0, 0, 2); wait_done();
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LB, 32'h13, 32'h0, 1, 32'hFFFFFF80, 0, 3); wait_done();
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LBU, 32'h13, 32'h0, 1, 32'h00000080, 0, 3); wait_done();
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LH, 32'h12, 32'h0, 1, 32'hFFFF8022, 0, 3); wait_done();
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LHU, 32'h12, 32'h0, 1, 32'h00008022, 0, 3); wait_done();
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LH, 32'h11, 32'h0, 1, 32'h00002233, 0, 3); wait_done();

        // Bytes AA,BB,CC,DD at 0x0E..0x11, then a word load across the boundary.
        exp_acc(3, 0, 4'b1111, 32'h0000AABB);
        send(ALU_SW, 32'h0C, 32'hBBAA0000, 1, 32'h0, 0, 2); wait_done();
        exp_acc(4, 0, 4'b1111, 32'hCCDD0000);
        send(ALU_SW, 32'h10, 32'h0000DDCC, 1, 32'h0, 0, 2); wait_done();
`ifdef LSU_MISALIGN_SPLIT_EN
        exp_acc(3, 1, 4'b0000, 32'h0);
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LW, 32'h0E, 32'h0, 1, 32'hDDCCBBAA, 0, 4); wait_done();
        // Halfword across the top of memory wraps to word 0.
        exp_acc(15'h7FFF, 0, 4'b0001, 32'h0000006B);
        exp_acc(15'h0000, 0, 4'b1000, 32'h5A000000);
        send(ALU_SH, 32'h1FFFF, 32'h00005A6B, 1, 32'h0, 0, 3); wait_done();
        exp_acc(15'h7FFF, 1, 4'b0000, 32'h0);
        exp_acc(15'h0000, 1, 4'b0000, 32'h0);
        send(ALU_LHU, 32'h1FFFF, 32'h0, 1, 32'h00005A6B, 0, 4); wait_done();
`else
        send(ALU_LW, 32'h0E, 32'h0, 1, 32'h0, 1, 1); wait_done();
        send(ALU_SH, 32'h1FFFF, 32'h00005A6B, 1, 32'h0, 1, 1); wait_done();
        send(ALU_LHU, 32'h1FFFF, 32'h0, 1, 32'h0, 1, 1); wait_done();
`endif

        // Illegal alucode: error response, no memory access.
        send(6'h3F, 32'h10, 32'h0, 1, 32'h0, 1, 1); wait_done();

        // Backpressure: response held while a competing request waits.
        bus.resp_ready = 1'b0;
        exp_acc(4, 1, 4'b0000, 32'h0);
        send(ALU_LW, 32'h10, 32'h0, 1, 32'h0000DDCC, 0, 3);
        t = 0;
        while (!bus.resp_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.resp_valid) fail_now("hold_resp_timeout");
        bus.req_valid = 1'b1; bus.req_alucode = ALU_SW; bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        wait_done();

        // Reset during ACC0 of a store: no response, strobes cleared next cycle.
        exp_acc(8, 0, 4'b1111, 32'h0DF0FECA);
        send(ALU_SW, 32'h20, 32'hCAFEF00D, 0, 32'h0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_mem_we", bus.mem_we, 0);
        check("abort_resp_valid", bus.resp_valid, 0);
        check("abort_req_ready", bus.req_ready, 1);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("end_resp_queue", rsp_q.size(), 0);
        check("end_acc_queue", acc_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
